// File: rtl/simple_pipe_pkg.sv
// Shared definitions for the 4-register pipeline issue path.
// Instruction layout: {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}.
package simple_pipe_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam logic [7:0] INST_NOP = 8'h00;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    function automatic logic [1:0] inst_op(input logic [7:0] inst);
        return inst[7:6];
    endfunction

    function automatic logic [1:0] inst_rs1(input logic [7:0] inst);
        return inst[5:4];
    endfunction

    function automatic logic [1:0] inst_rs2(input logic [7:0] inst);
        return inst[3:2];
    endfunction

    function automatic logic [1:0] inst_rd(input logic [7:0] inst);
        return inst[1:0];
    endfunction

endpackage

// File: rtl/simple_pipe_issue_arb_issue_slot.sv
// One-entry instruction buffer owned by a single requester.
// Ready is purely the registered empty flag, so there is no valid->ready path.
module issue_slot
    import simple_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_inst,
    output logic       in_ready,
    input  logic       clear,
    output logic       full,
    output logic [7:0] inst
);

    assign in_ready = ~full;

    // Capture on valid&&ready; the arbiter only clears a full slot, so the two never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            inst <= INST_NOP;
        end else if (clear) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            inst <= in_inst;
        end
    end

endmodule

// File: rtl/simple_pipe_issue_arb.sv
// Round-robin issue controller for two requesters sharing the pipeline
// instruction port, with write-ownership squashing and a drain handshake.
//
// state | meaning
// RUN   | grants allowed, slots issue round-robin
// DRAIN | no grants; waiting for issued writes to retire
// DONE  | quiesced, drain_done high until drain_req drops
module simple_pipe_issue_arb
    import simple_pipe_pkg::*;
#(
    parameter int         PIPE_DEPTH = 3,
    parameter logic [3:0] WMASK0     = 4'b0011,
    parameter logic [3:0] WMASK1     = 4'b1100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_inst,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_inst,
    output logic       req1_ready,
    output logic [7:0] issue_inst,
    output logic       issue_src,
    output logic       issue_vld,
    input  logic       drain_req,
    output logic       drain_done,
    output logic [1:0] err_illegal
);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [1:0]            slot_full;
    logic [1:0]            slot_clear;
    logic [7:0]            slot_inst0;
    logic [7:0]            slot_inst1;
    logic                  rr_last;
    logic                  grant_vld;
    logic                  grant_idx;
    logic                  illegal;
    logic [7:0]            sel_inst;
    logic [3:0]            sel_mask;
    logic [7:0]            issue_nxt;
    logic [PIPE_DEPTH-1:0] inflight;

    issue_slot u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (req0_valid),
        .in_inst  (req0_inst),
        .in_ready (req0_ready),
        .clear    (slot_clear[0]),
        .full     (slot_full[0]),
        .inst     (slot_inst0)
    );

    issue_slot u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (req1_valid),
        .in_inst  (req1_inst),
        .in_ready (req1_ready),
        .clear    (slot_clear[1]),
        .full     (slot_full[1]),
        .inst     (slot_inst1)
    );

    // Round-robin grant among full slots; the requester not served last wins a tie.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (state == RUN) begin
            if (slot_full[0] && slot_full[1]) begin
                grant_vld = 1'b1;
                grant_idx = ~rr_last;
            end else if (slot_full[0]) begin
                grant_vld = 1'b1;
            end else if (slot_full[1]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    assign slot_clear = {grant_vld & grant_idx, grant_vld & ~grant_idx};
    assign sel_inst   = grant_idx ? slot_inst1 : slot_inst0;
    assign sel_mask   = grant_idx ? WMASK1 : WMASK0;
    assign illegal    = grant_vld && (inst_op(sel_inst) != OP_NOP) && !sel_mask[inst_rd(sel_inst)];
    assign issue_nxt  = (grant_vld && !illegal) ? sel_inst : INST_NOP;

    // Issue register, round-robin pointer, sticky error flags and write-retire tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_inst  <= INST_NOP;
            issue_vld   <= 1'b0;
            issue_src   <= 1'b0;
            rr_last     <= 1'b1;
            err_illegal <= 2'b00;
            inflight    <= '0;
        end else begin
            issue_inst <= issue_nxt;
            issue_vld  <= grant_vld;
            if (grant_vld) begin
                issue_src <= grant_idx;
                rr_last   <= grant_idx;
            end
            if (illegal) begin
                err_illegal[grant_idx] <= 1'b1;
            end
            inflight <= {inflight[PIPE_DEPTH-2:0], (inst_op(issue_nxt) != OP_NOP)};
        end
    end

    // Drain state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain sequencing; dropping drain_req always returns to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (drain_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_nxt = RUN;
                end else if ((inflight == '0) && !issue_vld) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!drain_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign drain_done = (state == DONE);

endmodule
